mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single physical-memory line port between the I-cache miss path, which serves fetch, and the D-cache miss/writeback path. A three-state FSM grants one requester at a time, latches its address and data, and holds the memory command until `mem_resp`. It then routes the response back and returns to idle. D-cache requests win ties, and a starvation limit guarantees forward progress for fetch.

## Interface
Parameters:
- `LINE_W`, 256, cache line width in bits
- `ADDR_W`, 32, address width
- `STARVE_LIMIT`, 4, consecutive D grants allowed while an I request waits before I is forced

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `i_read` in 1: I-cache line read request; level, held until `i_resp`.
- `i_addr` in `ADDR_W`: I-cache line address.
- `i_rdata` out `LINE_W`: read line, valid when `i_resp`.
- `i_resp` out 1: one-cycle completion pulse to the I-cache.
- `d_read` in 1: D-cache line read request.
- `d_write` in 1: D-cache line writeback request.
- `d_addr` in `ADDR_W`: D-cache line address.
- `d_wdata` in `LINE_W`: writeback line.
- `d_rdata` out `LINE_W`: read line, valid when `d_resp`.
- `d_resp` out 1: one-cycle completion pulse to the D-cache.
- `mem_read` out 1: memory read command.
- `mem_write` out 1: memory write command.
- `mem_addr` out `ADDR_W`: latched address.
- `mem_wdata` out `LINE_W`: latched write line.
- `mem_rdata` in `LINE_W`: memory read data.
- `mem_resp` in 1: memory completion.
- `i_grant_cnt` out 32: count of I grants.
- `d_grant_cnt` out 32: count of D grants.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`.
- In `IDLE`, the winner is decided combinationally from the current requests. The state and latches update at the clock edge.
  - Only I requesting → `SERVE_I`.
  - Only D requesting (`d_read` or `d_write`) → `SERVE_D`.
  - Both requesting → `SERVE_D`, unless `starve_cnt == STARVE_LIMIT`, in which case → `SERVE_I`.
- On grant, these are latched:
  - `mem_addr`
  - `mem_wdata` (D only)
  - the op: write when `d_write`, else read. `d_write` takes precedence if `d_read` and `d_write` are both high.
- Command outputs:
  - `SERVE_I`: `mem_read=1`, `mem_write=0`.
  - `SERVE_D`: exactly one of `mem_read`/`mem_write`, per the latched op.
  - `IDLE`: both 0.
- On `mem_resp` in `SERVE_X`:
  - `X_resp=1` in that same cycle (combinational).
  - Next state is `IDLE`.
  - `mem_resp` is never routed to the other requester.
- `i_rdata` and `d_rdata` continuously pass through `mem_rdata`.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - increments, saturating, on a D grant while `i_read` is high;
  - clears on any I grant;
  - holds otherwise.
- A requester that deasserts mid-transaction does not abort the transaction. The command is held until `mem_resp`, and `X_resp` still pulses.
- `mem_resp` while in `IDLE` is ignored: no `X_resp`, no state change.
- Grant counters increment by 1 on each grant edge and wrap at 2^32.

## Timing
- Reset values:
  - state `IDLE`; `starve_cnt` 0; both grant counters 0;
  - `mem_read` = `mem_write` = 0;
  - `mem_addr` and `mem_wdata` 0;
  - `i_resp` = `d_resp` = 0.
- A request seen in `IDLE` at edge N gives a memory command from cycle N+1.
- Response is 0 cycles after `mem_resp`.
- Back-to-back transactions always have one `IDLE` cycle between them. The minimum turnaround from `mem_resp` to the next command is 2 cycles.
- `rst` while in `SERVE_*` returns to `IDLE` at that edge and drops the command. A later stale `mem_resp` is ignored.
- `mem_addr`, `mem_wdata` and the op are stable for the whole `SERVE_*` interval, even if requester inputs change.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum `{IDLE, SERVE_I, SERVE_D}`;
  - the `LINE_W`/`ADDR_W` default constants;
  - `mem_op_t` enum `{OP_READ, OP_WRITE}`.
- Sub-module `arb_grant_select`: purely combinational. It takes the requests and `starve_cnt` and produces grant_i / grant_d. `mem_port_arbiter` keeps the FSM, latches, counters and response routing.

## Test plan
- **Lone I read:** `i_read=1`, `i_addr=0x60`, memory responds 3 cycles after command → `mem_read` rises 1 cycle after the request with `mem_addr=0x60`; `i_resp` pulses exactly 1 cycle, coincident with `mem_resp`; `d_resp` stays 0; `i_grant_cnt=1`.
- **Tie with writeback:** `i_read` and `d_write` (`d_addr=0x1000`, `d_wdata=0xA5…`) asserted together → D is served first, with `mem_write=1` and `mem_wdata` latched. After its `mem_resp` there is one idle cycle, then I is served.
- **Starvation:** `i_read` held high while D issues 6 back-to-back reads, `STARVE_LIMIT=4` → exactly 4 D grants, then an I grant, then the remaining D grants; `starve_cnt` reads 0 after the I grant.
- **Latch stability:** change `d_addr` and `d_wdata` mid-`SERVE_D` → `mem_addr` and `mem_wdata` stay unchanged until `mem_resp`.
- **Spurious and abandoned:**
  - `mem_resp` pulsed in `IDLE` → no `X_resp`, state stays `IDLE`.
  - I deasserts `i_read` mid-serve → `mem_read` is held, and `i_resp` still pulses on `mem_resp`.
- **Reset mid-serve:** `rst` for 1 cycle during `SERVE_D` → next cycle has all `mem_*` commands 0, counters 0; a following `mem_resp` produces no `d_resp`.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and default widths for the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEFAULT_LINE_W = 256;
    localparam int DEFAULT_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : I-cache, D-cache and memory-side signals of the line port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic [31:0]       i_grant_cnt;
    logic [31:0]       d_grant_cnt;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr,
               mem_wdata, i_grant_cnt, d_grant_cnt
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr,
               mem_wdata, i_grant_cnt, d_grant_cnt
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_grant_select.sv
`default_nettype none
// ============================================================================
// Module   : arb_grant_select
// Brief    : Combinational winner pick; D wins ties unless I has been starved.
// Revision : 1.0 - initial release
// ============================================================================
module arb_grant_select #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             i_icache_req,
    input  logic             i_dcache_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant_i,
    output logic             o_grant_d
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        o_grant_i = 1'b0;
        o_grant_d = 1'b0;
        if (i_icache_req && i_dcache_req) begin
            if (i_starve_cnt == C_LIMIT) begin
                o_grant_i = 1'b1;
            end else begin
                o_grant_d = 1'b1;
            end
        end else if (i_icache_req) begin
            o_grant_i = 1'b1;
        end else if (i_dcache_req) begin
            o_grant_d = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory line port between I-cache and D-cache miss paths.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W       = DEFAULT_LINE_W,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0]       i_grant_cnt_q, i_grant_cnt_d;
    logic [31:0]       d_grant_cnt_q, d_grant_cnt_d;

    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_d_req = bus.d_read | bus.d_write;

    arb_grant_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant_select (
        .i_icache_req (bus.i_read),
        .i_dcache_req (w_d_req),
        .i_starve_cnt (starve_cnt_q),
        .o_grant_i    (w_grant_i),
        .o_grant_d    (w_grant_d)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        starve_cnt_d  = starve_cnt_q;
        i_grant_cnt_d = i_grant_cnt_q;
        d_grant_cnt_d = d_grant_cnt_q;
        case (state_q)
            IDLE: begin
                if (w_grant_i) begin
                    state_d       = SERVE_I;
                    op_d          = OP_READ;
                    addr_d        = bus.i_addr;
                    starve_cnt_d  = '0;
                    i_grant_cnt_d = i_grant_cnt_q + 32'd1;
                end else if (w_grant_d) begin
                    state_d       = SERVE_D;
                    op_d          = bus.d_write ? OP_WRITE : OP_READ;
                    addr_d        = bus.d_addr;
                    wdata_d       = bus.d_wdata;
                    d_grant_cnt_d = d_grant_cnt_q + 32'd1;
                    // Only a D grant that bypasses a waiting fetch counts toward starvation.
                    if (bus.i_read && (starve_cnt_q != C_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= OP_READ;
            addr_q        <= '0;
            wdata_q       <= '0;
            starve_cnt_q  <= '0;
            i_grant_cnt_q <= '0;
            d_grant_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            starve_cnt_q  <= starve_cnt_d;
            i_grant_cnt_q <= i_grant_cnt_d;
            d_grant_cnt_q <= d_grant_cnt_d;
        end
    end

    assign bus.mem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && (op_q == OP_READ));
    assign bus.mem_write   = (state_q == SERVE_D) && (op_q == OP_WRITE);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.i_resp      = (state_q == SERVE_I) && bus.mem_resp;
    assign bus.d_resp      = (state_q == SERVE_D) && bus.mem_resp;
    assign bus.i_rdata     = bus.mem_rdata;
    assign bus.d_rdata     = bus.mem_rdata;
    assign bus.i_grant_cnt = i_grant_cnt_q;
    assign bus.d_grant_cnt = d_grant_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LINE_W       = 256;
    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .LINE_W       (LINE_W),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_read    = 1'b0;
        bus.i_addr    = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ir, dw, mr;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic        e_wd;
        logic        e_ir, e_dr;
        int          e_ic, e_dc;
    } vec_t;

    function automatic vec_t mk(input logic ir, dw, mr, rd, wr, input logic [31:0] a,
                                input logic wd, eir, edr, input int ic, dc);
        vec_t v;
        v.ir = ir; v.dw = dw; v.mr = mr; v.e_rd = rd; v.e_wr = wr; v.e_addr = a;
        v.e_wd = wd; v.e_ir = eir; v.e_dr = edr; v.e_ic = ic; v.e_dc = dc;
        return v;
    endfunction

    vec_t tbl [15];
    logic [LINE_W-1:0] pat_a5;

    // Reference model state: owner 0 = none, 1 = I, 2 = D.
    int                m_owner = 0;
    bit                m_wr = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    int                m_starve = 0;
    logic [31:0]       m_icnt = '0, m_dcnt = '0;

    initial begin
        logic [31:0]       seq;
        int                dgot, igot;
        logic [31:0]       pi, pd;
        logic [LINE_W-1:0] pat_st;

        pat_a5 = {8{32'hA5A5_A5A5}};
        clear_inputs();

        // Lone I read with 3-cycle memory latency, then tie with a writeback,
        // abandoned I request and a spurious mem_resp in IDLE.
        tbl[0]  = mk(1,0,0, 0,0,32'h0000_0000, 0, 0,0, 0,0);
        tbl[1]  = mk(1,0,0, 1,0,32'h0000_0060, 0, 0,0, 1,0);
        tbl[2]  = mk(1,0,0, 1,0,32'h0000_0060, 0, 0,0, 1,0);
        tbl[3]  = mk(1,0,0, 1,0,32'h0000_0060, 0, 0,0, 1,0);
        tbl[4]  = mk(1,0,1, 1,0,32'h0000_0060, 0, 1,0, 1,0);
        tbl[5]  = mk(0,0,0, 0,0,32'h0000_0060, 0, 0,0, 1,0);
        tbl[6]  = mk(1,1,0, 0,0,32'h0000_0060, 0, 0,0, 1,0);
        tbl[7]  = mk(1,1,0, 0,1,32'h0000_1000, 1, 0,0, 1,1);
        tbl[8]  = mk(1,1,1, 0,1,32'h0000_1000, 1, 0,1, 1,1);
        tbl[9]  = mk(1,0,0, 0,0,32'h0000_1000, 1, 0,0, 1,1);
        tbl[10] = mk(1,0,0, 1,0,32'h0000_0060, 1, 0,0, 2,1);
        tbl[11] = mk(0,0,0, 1,0,32'h0000_0060, 1, 0,0, 2,1);
        tbl[12] = mk(0,0,1, 1,0,32'h0000_0060, 1, 1,0, 2,1);
        tbl[13] = mk(0,0,1, 0,0,32'h0000_0060, 1, 0,0, 2,1);
        tbl[14] = mk(0,0,0, 0,0,32'h0000_0060, 1, 0,0, 2,1);

        // Reset state, with a stray mem_resp present.
        bus.mem_resp = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read",  bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_i_resp",    bus.i_resp, 0);
        chk("rst_d_resp",    bus.d_resp, 0);
        chk("rst_i_cnt",     bus.i_grant_cnt, 0);
        chk("rst_d_cnt",     bus.d_grant_cnt, 0);
        chk("rst_starve",    dut.starve_cnt_q, 0);

        foreach (tbl[r]) begin
            @(posedge clk); #1;
            rst          = 1'b0;
            bus.i_read   = tbl[r].ir;
            bus.i_addr   = 32'h60;
            bus.d_read   = 1'b0;
            bus.d_write  = tbl[r].dw;
            bus.d_addr   = 32'h1000;
            bus.d_wdata  = pat_a5;
            bus.mem_resp = tbl[r].mr;
            @(negedge clk);
            chk($sformatf("tbl%0d_mem_read", r),  bus.mem_read, tbl[r].e_rd);
            chk($sformatf("tbl%0d_mem_write", r), bus.mem_write, tbl[r].e_wr);
            chk($sformatf("tbl%0d_mem_addr", r),  bus.mem_addr, tbl[r].e_addr);
            chk($sformatf("tbl%0d_mem_wdata", r), bus.mem_wdata, tbl[r].e_wd ? pat_a5 : '0);
            chk($sformatf("tbl%0d_i_resp", r),    bus.i_resp, tbl[r].e_ir);
            chk($sformatf("tbl%0d_d_resp", r),    bus.d_resp, tbl[r].e_dr);
            chk($sformatf("tbl%0d_i_cnt", r),     bus.i_grant_cnt, tbl[r].e_ic);
            chk($sformatf("tbl%0d_d_cnt", r),     bus.d_grant_cnt, tbl[r].e_dc);
        end

        // Starvation: fetch held while D issues 6 back-to-back reads.
        do_reset();
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        seq = '0; dgot = 0; igot = 0; pi = '0; pd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.i_grant_cnt != pi) begin
                seq = {seq[27:0], 4'h1};
                igot++;
                chk("starve_cleared", dut.starve_cnt_q, 0);
            end
            if (bus.d_grant_cnt != pd) begin
                seq = {seq[27:0], 4'hD};
                dgot++;
            end
            pi = bus.i_grant_cnt;
            pd = bus.d_grant_cnt;
            if (dgot >= 6) bus.d_read = 1'b0;
            if (igot >= 1) bus.i_read = 1'b0;
            bus.mem_resp = bus.mem_read | bus.mem_write;
        end
        chk("starve_order", seq, 32'h0DDD_D1DD);
        chk("starve_i_cnt", bus.i_grant_cnt, 1);
        chk("starve_d_cnt", bus.d_grant_cnt, 6);

        // Latched address/data/op hold while the D-cache inputs wander.
        do_reset();
        pat_st       = {8{32'h1234_5678}};
        bus.d_write  = 1'b1;
        bus.d_addr   = 32'h2000;
        bus.d_wdata  = pat_st;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.d_write = 1'b0;
            bus.d_read  = 1'b1;
            bus.d_addr  = $urandom;
            bus.d_wdata = {8{$urandom}};
            @(negedge clk);
            chk("latch_mem_write", bus.mem_write, 1);
            chk("latch_mem_read",  bus.mem_read, 0);
            chk("latch_mem_addr",  bus.mem_addr, 32'h2000);
            chk("latch_mem_wdata", bus.mem_wdata, pat_st);
        end
        @(posedge clk); #1;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("latch_d_resp", bus.d_resp, 1);
        chk("latch_i_resp", bus.i_resp, 0);
        @(posedge clk); #1;
        clear_inputs();

        // Reset mid-serve drops the command; a stale mem_resp is ignored.
        do_reset();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h3000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_serving", bus.mem_read, 1);
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.d_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_mem_read",  bus.mem_read, 0);
        chk("rstmid_mem_write", bus.mem_write, 0);
        chk("rstmid_d_cnt",     bus.d_grant_cnt, 0);
        chk("rstmid_i_cnt",     bus.i_grant_cnt, 0);
        @(posedge clk); #1;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("rstmid_stale_d_resp", bus.d_resp, 0);
        chk("rstmid_stale_i_resp", bus.i_resp, 0);
        @(posedge clk); #1;
        bus.mem_resp = 1'b0;

        // Random traffic against the reference model.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            rst           = (c == 0) || ($urandom_range(63) == 0);
            bus.i_read    = ($urandom_range(3) != 0);
            bus.d_read    = ($urandom_range(2) == 0);
            bus.d_write   = ($urandom_range(2) == 0);
            bus.i_addr    = $urandom;
            bus.d_addr    = $urandom;
            bus.d_wdata   = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            bus.mem_resp  = ($urandom_range(2) == 0);
            @(negedge clk);
            if (c > 0) begin
                chk("rnd_mem_read",  bus.mem_read, (m_owner == 1) || (m_owner == 2 && !m_wr));
                chk("rnd_mem_write", bus.mem_write, (m_owner == 2) && m_wr);
                chk("rnd_mem_addr",  bus.mem_addr, m_addr);
                chk("rnd_mem_wdata", bus.mem_wdata, m_wdata);
                chk("rnd_i_resp",    bus.i_resp, (m_owner == 1) && bus.mem_resp);
                chk("rnd_d_resp",    bus.d_resp, (m_owner == 2) && bus.mem_resp);
                chk("rnd_i_rdata",   bus.i_rdata, bus.mem_rdata);
                chk("rnd_d_rdata",   bus.d_rdata, bus.mem_rdata);
                chk("rnd_i_cnt",     bus.i_grant_cnt, m_icnt);
                chk("rnd_d_cnt",     bus.d_grant_cnt, m_dcnt);
                chk("rnd_starve",    dut.starve_cnt_q, m_starve);
            end
            // Advance the model to the upcoming clock edge.
            if (rst) begin
                m_owner = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
                m_starve = 0; m_icnt = '0; m_dcnt = '0;
            end else if (m_owner == 0) begin
                if (bus.i_read && (!(bus.d_read || bus.d_write) || m_starve == STARVE_LIMIT)) begin
                    m_owner  = 1;
                    m_wr     = 0;
                    m_addr   = bus.i_addr;
                    m_starve = 0;
                    m_icnt   = m_icnt + 1;
                end else if (bus.d_read || bus.d_write) begin
                    m_owner = 2;
                    m_wr    = bus.d_write;
                    m_addr  = bus.d_addr;
                    m_wdata = bus.d_wdata;
                    m_dcnt  = m_dcnt + 1;
                    if (bus.i_read && m_starve < STARVE_LIMIT) m_starve++;
                end
            end else if (bus.mem_resp) begin
                m_owner = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
